// File: rtl/brick_pkg.sv
// Shared types, default playfield geometry and the brick/ball overlap test
// for the falling-brick scheduler.
package brick_pkg;

  localparam int PKG_COORD_W = 10;
  localparam int LFSR_W      = 10;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 10'h001;

  localparam int DEF_BRICK_W = 57;
  localparam int DEF_BRICK_H = 19;
  localparam int DEF_BALL_SZ = 20;
  localparam int DEF_FLOOR_Y = 458;
  localparam int DEF_X_MAX   = 583;

  typedef enum logic [2:0] {
    ST_IDLE, ST_CLEAR, ST_WAIT, ST_SCAN, ST_MOVE, ST_SPAWN, ST_OVER
  } state_t;

  typedef struct packed {
    logic                   valid;
    logic [PKG_COORD_W-1:0] x;
    logic [PKG_COORD_W-1:0] y;
  } slot_t;

  localparam int EXT_W = PKG_COORD_W + 1;

  // Sums are widened by one bit so boxes near the coordinate limit never wrap.
  function automatic logic brick_overlap(
    input logic [PKG_COORD_W-1:0] x,
    input logic [PKG_COORD_W-1:0] y,
    input logic [PKG_COORD_W-1:0] bx,
    input logic [PKG_COORD_W-1:0] by,
    input int                     bw,
    input int                     bh,
    input int                     bs
  );
    logic [EXT_W-1:0] x_e, y_e, bx_e, by_e, x_r, y_b, bx_r, by_b;
    x_e  = {1'b0, x};
    y_e  = {1'b0, y};
    bx_e = {1'b0, bx};
    by_e = {1'b0, by};
    x_r  = x_e + EXT_W'(bw);
    y_b  = y_e + EXT_W'(bh);
    bx_r = bx_e + EXT_W'(bs);
    by_b = by_e + EXT_W'(bs);
    return (bx_e <= x_r) && (bx_r >= x_e) && (by_e <= y_b) && (by_b >= y_e);
  endfunction

endpackage

// File: rtl/brick_lfsr.sv
// Free-running 10-bit Fibonacci LFSR (x^10 + x^7 + 1) used for spawn columns.
module brick_lfsr
  import brick_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  output logic [LFSR_W-1:0] lfsr
);

  logic [LFSR_W-1:0] lfsr_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr_reg <= LFSR_SEED;
    else     lfsr_reg <= {lfsr_reg[LFSR_W-2:0], lfsr_reg[9] ^ lfsr_reg[6]};
  end

  assign lfsr = lfsr_reg;

endmodule

// File: rtl/brick_field_ctrl.sv
// Per-frame scheduler for the brick pool: collision scan, downward move and
// spawn, plus score and sticky game-over.
module brick_field_ctrl
  import brick_pkg::*;
#(
  parameter int NUM_SLOTS   = 8,
  parameter int COORD_W     = PKG_COORD_W,
  parameter int BRICK_W     = DEF_BRICK_W,
  parameter int BRICK_H     = DEF_BRICK_H,
  parameter int BALL_SZ     = DEF_BALL_SZ,
  parameter int FLOOR_Y     = DEF_FLOOR_Y,
  parameter int X_MAX       = DEF_X_MAX,
  parameter int SPAWN_TICKS = 16,
  parameter int FALL_TICKS  = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         frame_tick,
  input  logic [COORD_W-1:0]           ball_x,
  input  logic [COORD_W-1:0]           ball_y,
  input  logic [$clog2(NUM_SLOTS)-1:0] rd_idx,
  output logic                         rd_valid,
  output logic [COORD_W-1:0]           rd_x,
  output logic [COORD_W-1:0]           rd_y,
  output logic                         hit,
  output logic [$clog2(NUM_SLOTS)-1:0] hit_idx,
  output logic [15:0]                  score,
  output logic                         game_over,
  output logic                         busy
);

  localparam int IDX_W   = $clog2(NUM_SLOTS);
  localparam int FALL_W  = $clog2(FALL_TICKS + 1);
  localparam int SPAWN_W = $clog2(SPAWN_TICKS + 1);

  state_t               state_reg, state_next;
  slot_t                slots_reg [NUM_SLOTS];
  slot_t                slots_next[NUM_SLOTS];
  logic [IDX_W-1:0]     idx_reg, idx_next;
  logic [COORD_W-1:0]   ball_x_reg, ball_x_next, ball_y_reg, ball_y_next;
  logic [FALL_W-1:0]    fall_cnt_reg, fall_cnt_next;
  logic [SPAWN_W-1:0]   spawn_cnt_reg, spawn_cnt_next;
  logic [15:0]          score_reg, score_next;
  logic                 game_over_reg, game_over_next;
  logic                 hit_reg, hit_next;
  logic [IDX_W-1:0]     hit_idx_reg, hit_idx_next;

  logic [LFSR_W-1:0]      lfsr;
  logic [PKG_COORD_W-1:0] spawn_x;
  logic [PKG_COORD_W-1:0] fall_y   [NUM_SLOTS];
  logic [NUM_SLOTS-1:0]   floor_hit;
  logic                   fall_now, scan_hit, free_found;
  logic [IDX_W-1:0]       free_idx;

  brick_lfsr u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .lfsr (lfsr)
  );

  assign fall_now = (fall_cnt_reg == FALL_W'(FALL_TICKS - 1));
  assign spawn_x  = (lfsr < LFSR_W'(X_MAX)) ? lfsr : lfsr - LFSR_W'(X_MAX);
  assign scan_hit = slots_reg[idx_reg].valid &&
                    brick_overlap(slots_reg[idx_reg].x, slots_reg[idx_reg].y,
                                  ball_x_reg, ball_y_reg, BRICK_W, BRICK_H, BALL_SZ);

  // Post-move y and floor test per slot; only consumed in MOVE.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
      assign fall_y[gi]    = slots_reg[gi].y +
                             {{(PKG_COORD_W-1){1'b0}}, fall_now & slots_reg[gi].valid};
      assign floor_hit[gi] = slots_reg[gi].valid && (fall_y[gi] >= PKG_COORD_W'(FLOOR_Y));
    end
  endgenerate

  // Downward search leaves the lowest free index selected.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!slots_reg[i].valid) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  always_comb begin
    state_next     = state_reg;
    slots_next     = slots_reg;
    idx_next       = idx_reg;
    ball_x_next    = ball_x_reg;
    ball_y_next    = ball_y_reg;
    fall_cnt_next  = fall_cnt_reg;
    spawn_cnt_next = spawn_cnt_reg;
    score_next     = score_reg;
    game_over_next = game_over_reg;
    hit_next       = 1'b0;
    hit_idx_next   = hit_idx_reg;
    case (state_reg)
      ST_IDLE: if (start) state_next = ST_CLEAR;
      ST_CLEAR: begin
        for (int i = 0; i < NUM_SLOTS; i++) slots_next[i].valid = 1'b0;
        score_next     = '0;
        fall_cnt_next  = '0;
        spawn_cnt_next = '0;
        game_over_next = 1'b0;
        state_next     = ST_WAIT;
      end
      ST_WAIT: begin
        if (frame_tick) begin
          ball_x_next = ball_x;
          ball_y_next = ball_y;
          idx_next    = '0;
          state_next  = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (scan_hit) begin
          slots_next[idx_reg].valid = 1'b0;
          hit_next     = 1'b1;
          hit_idx_next = idx_reg;
          if (score_reg != 16'hFFFF) score_next = score_reg + 16'd1;
        end
        if (idx_reg == IDX_W'(NUM_SLOTS - 1)) state_next = ST_MOVE;
        else                                  idx_next   = idx_reg + 1'b1;
      end
      ST_MOVE: begin
        if (fall_now) begin
          for (int i = 0; i < NUM_SLOTS; i++) slots_next[i].y = fall_y[i];
          fall_cnt_next = '0;
        end else begin
          fall_cnt_next = fall_cnt_reg + 1'b1;
        end
        if (|floor_hit) begin
          game_over_next = 1'b1;
          state_next     = ST_OVER;
        end else begin
          state_next     = ST_SPAWN;
        end
      end
      ST_SPAWN: begin
        if (spawn_cnt_reg == SPAWN_W'(SPAWN_TICKS - 1)) begin
          spawn_cnt_next = '0;
          if (free_found) begin
            slots_next[free_idx].valid = 1'b1;
            slots_next[free_idx].x     = spawn_x;
            slots_next[free_idx].y     = '0;
          end
        end else begin
          spawn_cnt_next = spawn_cnt_reg + 1'b1;
        end
        state_next = ST_WAIT;
      end
      ST_OVER: if (start) state_next = ST_CLEAR;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      for (int i = 0; i < NUM_SLOTS; i++) slots_reg[i] <= '0;
      idx_reg       <= '0;
      ball_x_reg    <= '0;
      ball_y_reg    <= '0;
      fall_cnt_reg  <= '0;
      spawn_cnt_reg <= '0;
      score_reg     <= '0;
      game_over_reg <= 1'b0;
      hit_reg       <= 1'b0;
      hit_idx_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      slots_reg     <= slots_next;
      idx_reg       <= idx_next;
      ball_x_reg    <= ball_x_next;
      ball_y_reg    <= ball_y_next;
      fall_cnt_reg  <= fall_cnt_next;
      spawn_cnt_reg <= spawn_cnt_next;
      score_reg     <= score_next;
      game_over_reg <= game_over_next;
      hit_reg       <= hit_next;
      hit_idx_reg   <= hit_idx_next;
    end
  end

  assign rd_valid  = slots_reg[rd_idx].valid;
  assign rd_x      = slots_reg[rd_idx].x;
  assign rd_y      = slots_reg[rd_idx].y;
  assign hit       = hit_reg;
  assign hit_idx   = hit_idx_reg;
  assign score     = score_reg;
  assign game_over = game_over_reg;
  assign busy      = (state_reg == ST_CLEAR) || (state_reg == ST_SCAN) ||
                     (state_reg == ST_MOVE)  || (state_reg == ST_SPAWN);

endmodule
